rstatus_monitor: RTL and testbench
==================================

// Module: rstatus_monitor
// PURPOSE
//  Consumer end of the rstatus error-code path. Samples error events (error_bool + rstatus code 1..5)
//  at writeback, classifies them, and keeps per-class saturating counters. Queues {code,pc} records
//  in a 4-deep FIFO for a debug/host reader over a valid/ready handshake. Sits beside the register
//  file write port; never stalls the pipeline.
// PARAMETERS
//  DEPTH     4   FIFO entries (power of two, >=2)
//  CNT_W     8   width of each saturating counter
//  PC_W      12  width of captured PC (imem address width)
// PORTS
//  clock      in   1      rising-edge clock
//  reset      in   1      synchronous, active-high; clears all state
//  wb_valid   in   1      writeback stage holds a real instruction this cycle
//  wb_error   in   1      error_bool from status generator (overflow/exception)
//  wb_code    in   32     rstatus value; legal codes 1..5 (add,addi,sub,mul,div)
//  wb_pc      in   PC_W   PC of the writeback instruction
//  rd_valid   out  1      FIFO head holds a record
//  rd_ready   in   1      reader accepts head this cycle
//  rd_code    out  3      head class: 1..5 = legal code, 0 = unknown code
//  rd_pc      out  PC_W   head PC
//  cnt_sel    in   3      counter select (see BEHAVIOUR)
//  cnt_out    out  CNT_W  selected counter, combinational from cnt_sel
//  clr_cnt    in   1      synchronous clear of all counters (FIFO untouched)
//  overflow   out  1      sticky: an event was dropped because FIFO was full
// BEHAVIOUR
//  - Event: ev = wb_valid & wb_error, sampled each rising edge. wb_valid=0 or wb_error=0 -> ignored.
//  - Classify: wb_code in 1..5 -> class=wb_code[2:0]; any other value (0, 6.., upper bits set) -> class 0.
//  - Counters (CNT_W, saturate at all-ones, never wrap): idx 0 unknown-class events, 1..5 per class,
//    6 dropped events, 7 total events (every ev, dropped or not). cnt_out = counter[cnt_sel].
//  - Counter update lands 1 cycle after ev; cnt_out reflects it the cycle after that edge.
//  - clr_cnt and ev same cycle: clear wins, event not counted; FIFO push still occurs.
//  - FIFO: push on ev if not full OR pop happens same cycle; pop when rd_valid & rd_ready.
//    Record written visible on rd_* the cycle after push (1-cycle latency), first-word-fall-through.
//  - rd_code/rd_pc stable while rd_valid & ~rd_ready. rd_* values undefined-but-held when rd_valid=0
//    (implementation drives last head, bench must not check).
//  - Full and ev and no pop: record dropped, counter 6 increments, overflow set (sticky until reset).
//  - Empty: rd_ready ignored, pointers unchanged. Push+pop while empty: push only (no bypass).
//  - Pointers log2(DEPTH) bits + 1 wrap bit; full = ptrs equal except wrap bit; empty = fully equal.
//  - Reset values: rd_valid=0, rd_code=0, rd_pc=0, overflow=0, all counters 0, pointers 0.
//  - Reset mid-operation: queued records discarded; an ev in the reset cycle is ignored.
// TESTING
//  1 reset, one ev code=1 pc=0x010, rd_ready=0 -> next cycle rd_valid=1 rd_code=1 rd_pc=0x010;
//    cnt_sel=1 -> 1, cnt_sel=7 -> 1; hold 3 cycles, outputs stable.
//  2 ev codes 2,3,4,5,1 back-to-back, rd_ready=0 -> first 4 queued, 5th dropped: overflow=1,
//    cnt[6]=1, cnt[7]=5; drain -> codes 2,3,4,5 in order then rd_valid=0.
//  3 FIFO full, ev code=5 with rd_ready=1 same cycle -> no drop, overflow stays 0, count stays 4.
//  4 ev code=0, code=6, code=32'h0001_0001 -> three records rd_code=0, cnt[0]=3; wb_error=1 with
//    wb_valid=0 -> no record, no count.
//  5 260 ev of code=3 with rd_ready=1 -> cnt[3]=255 saturated; clr_cnt with ev -> all counters 0.
//  6 3 records queued, assert reset 1 cycle -> rd_valid=0, overflow=0, cnt_out=0 for all cnt_sel.

Source files
------------

// File: rtl/rstatus_monitor.sv
// rstatus_monitor: classifies writeback error events, keeps saturating
// per-class counters and queues {class, pc} records for a debug reader.
module rstatus_monitor #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    parameter int PC_W  = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wb_valid,
    input  logic             wb_error,
    input  logic [31:0]      wb_code,
    input  logic [PC_W-1:0]  wb_pc,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [2:0]       rd_code,
    output logic [PC_W-1:0]  rd_pc,
    input  logic [2:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_out,
    input  logic             clr_cnt,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [2:0]      code;
        logic [PC_W-1:0] pc;
    } rec_t;

    rec_t             mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic [CNT_W-1:0] cnt [8];

    logic       ev, full, empty, pop, push, drop;
    logic [2:0] cls;
    logic [7:0] inc;
    rec_t       head;

    // An event in the reset cycle is discarded along with everything else.
    assign ev    = wb_valid & wb_error & ~reset;
    assign cls   = (wb_code >= 32'd1 && wb_code <= 32'd5) ? wb_code[2:0] : 3'd0;
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // rd_ready is ignored while empty, so push+pop on empty is a plain push.
    assign pop   = ~empty & rd_ready;
    assign push  = ev & (~full | pop);
    assign drop  = ev & full & ~pop;

    assign head     = mem[rptr[AW-1:0]];
    assign rd_valid = ~empty;
    assign rd_code  = head.code;
    assign rd_pc    = head.pc;
    assign cnt_out  = cnt[cnt_sel];

    // One-hot of the counters bumped by this cycle's event.
    always_comb begin
        inc = '0;
        if (ev) begin
            inc[cls] = 1'b1;
            inc[7]   = 1'b1;
            if (drop) inc[6] = 1'b1;
        end
    end

    // FIFO storage and pointers; storage is cleared so rd_* read 0 out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= '{code: cls, pc: wb_pc};
                wptr <= wptr + (AW+1)'(1);
            end
            if (pop) rptr <= rptr + (AW+1)'(1);
        end
    end

    // Saturating counters; clear beats a same-cycle event.
    always_ff @(posedge clock) begin
        if (reset || clr_cnt) begin
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++)
                if (inc[i] && cnt[i] != {CNT_W{1'b1}}) cnt[i] <= cnt[i] + CNT_W'(1);
        end
    end

    // Sticky drop flag, only reset clears it.
    always_ff @(posedge clock) begin
        if (reset)     overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_rstatus_monitor.sv
// Directed bench for rstatus_monitor: inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_rstatus_monitor;
    logic        clock = 0;
    logic        reset = 1;
    logic        wb_valid = 0, wb_error = 0;
    logic [31:0] wb_code = 0;
    logic [11:0] wb_pc = 0;
    logic        rd_valid, rd_ready = 0;
    logic [2:0]  rd_code;
    logic [11:0] rd_pc;
    logic [2:0]  cnt_sel = 0;
    logic [7:0]  cnt_out;
    logic        clr_cnt = 0;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    rstatus_monitor #(.DEPTH(4), .CNT_W(8), .PC_W(12)) dut (
        .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_error(wb_error),
        .wb_code(wb_code), .wb_pc(wb_pc), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_code(rd_code), .rd_pc(rd_pc), .cnt_sel(cnt_sel), .cnt_out(cnt_out),
        .clr_cnt(clr_cnt), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wb_valid = 0; wb_error = 0; rd_ready = 0; clr_cnt = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        cyc();
        reset = 0;
    endtask

    task automatic ev(input logic [31:0] code, input logic [11:0] pc);
        wb_valid = 1; wb_error = 1; wb_code = code; wb_pc = pc;
        cyc();
        wb_valid = 0; wb_error = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        checks++; if (rd_code !== 3'd0) begin errors++; $display("FAIL reset_rd_code got %0d want 0", rd_code); end
        checks++; if (rd_pc !== 12'h0) begin errors++; $display("FAIL reset_rd_pc got %h want 000", rd_pc); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        for (int s = 0; s < 8; s++) begin
            cnt_sel = 3'(s); #1;
            checks++; if (cnt_out !== 8'd0) begin errors++; $display("FAIL reset_cnt%0d got %0d want 0", s, cnt_out); end
        end
    endtask

    task automatic test_single();
        do_reset();
        ev(32'd1, 12'h010);
        cnt_sel = 3'd1; #1;
        checks++; if (cnt_out !== 8'd1) begin errors++; $display("FAIL single_cnt1 got %0d want 1", cnt_out); end
        cnt_sel = 3'd7; #1;
        checks++; if (cnt_out !== 8'd1) begin errors++; $display("FAIL single_cnt7 got %0d want 1", cnt_out); end
        for (int h = 0; h < 4; h++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_code !== 3'd1 || rd_pc !== 12'h010) begin
                errors++;
                $display("FAIL single_head cyc%0d got v=%b c=%0d pc=%h want v=1 c=1 pc=010", h, rd_valid, rd_code, rd_pc);
            end
            cyc();
        end
    endtask

    task automatic test_overflow();
        logic [2:0] exp_codes [4];
        exp_codes = '{3'd2, 3'd3, 3'd4, 3'd5};
        do_reset();
        ev(32'd2, 12'h100); ev(32'd3, 12'h101); ev(32'd4, 12'h102);
        ev(32'd5, 12'h103); ev(32'd1, 12'h104);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        cnt_sel = 3'd6; #1;
        checks++; if (cnt_out !== 8'd1) begin errors++; $display("FAIL ovf_cnt6 got %0d want 1", cnt_out); end
        cnt_sel = 3'd7; #1;
        checks++; if (cnt_out !== 8'd5) begin errors++; $display("FAIL ovf_cnt7 got %0d want 5", cnt_out); end
        rd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_code !== exp_codes[i] || rd_pc !== 12'(12'h100 + i)) begin
                errors++;
                $display("FAIL ovf_drain%0d got v=%b c=%0d pc=%h want v=1 c=%0d pc=%h", i, rd_valid, rd_code, rd_pc, exp_codes[i], 12'(12'h100 + i));
            end
            cyc();
        end
        rd_ready = 0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", rd_valid); end
    endtask

    task automatic test_full_pop();
        int n;
        do_reset();
        ev(32'd1, 12'h200); ev(32'd2, 12'h201); ev(32'd3, 12'h202); ev(32'd4, 12'h203);
        rd_ready = 1;
        ev(32'd5, 12'h204);
        rd_ready = 0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow got %b want 0", overflow); end
        cnt_sel = 3'd6; #1;
        checks++; if (cnt_out !== 8'd0) begin errors++; $display("FAIL fullpop_cnt6 got %0d want 0", cnt_out); end
        checks++; if (rd_code !== 3'd2) begin errors++; $display("FAIL fullpop_head got %0d want 2", rd_code); end
        n = 0;
        rd_ready = 1;
        while (rd_valid === 1'b1 && n < 10) begin
            n++;
            cyc();
        end
        rd_ready = 0;
        checks++; if (n != 4) begin errors++; $display("FAIL fullpop_count got %0d want 4", n); end
    endtask

    task automatic test_unknown();
        do_reset();
        ev(32'd0, 12'h300); ev(32'd6, 12'h301); ev(32'h0001_0001, 12'h302);
        wb_valid = 0; wb_error = 1; wb_code = 32'd2; wb_pc = 12'h303;
        cyc();
        wb_error = 0;
        cnt_sel = 3'd0; #1;
        checks++; if (cnt_out !== 8'd3) begin errors++; $display("FAIL unk_cnt0 got %0d want 3", cnt_out); end
        cnt_sel = 3'd2; #1;
        checks++; if (cnt_out !== 8'd0) begin errors++; $display("FAIL unk_cnt2 got %0d want 0", cnt_out); end
        cnt_sel = 3'd7; #1;
        checks++; if (cnt_out !== 8'd3) begin errors++; $display("FAIL unk_cnt7 got %0d want 3", cnt_out); end
        rd_ready = 1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_code !== 3'd0 || rd_pc !== 12'(12'h300 + i)) begin
                errors++;
                $display("FAIL unk_drain%0d got v=%b c=%0d pc=%h want v=1 c=0 pc=%h", i, rd_valid, rd_code, rd_pc, 12'(12'h300 + i));
            end
            cyc();
        end
        rd_ready = 0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL unk_empty got %b want 0", rd_valid); end
    endtask

    task automatic test_saturate();
        do_reset();
        rd_ready = 1;
        for (int i = 0; i < 260; i++) ev(32'd3, 12'(i));
        cnt_sel = 3'd3; #1;
        checks++; if (cnt_out !== 8'd255) begin errors++; $display("FAIL sat_cnt3 got %0d want 255", cnt_out); end
        cnt_sel = 3'd7; #1;
        checks++; if (cnt_out !== 8'd255) begin errors++; $display("FAIL sat_cnt7 got %0d want 255", cnt_out); end
        cnt_sel = 3'd6; #1;
        checks++; if (cnt_out !== 8'd0) begin errors++; $display("FAIL sat_cnt6 got %0d want 0", cnt_out); end
        cyc();
        rd_ready = 0;
        clr_cnt = 1;
        ev(32'd3, 12'h3AA);
        clr_cnt = 0;
        for (int s = 0; s < 8; s++) begin
            cnt_sel = 3'(s); #1;
            checks++; if (cnt_out !== 8'd0) begin errors++; $display("FAIL clr_cnt%0d got %0d want 0", s, cnt_out); end
        end
        checks++;
        if (rd_valid !== 1'b1 || rd_pc !== 12'h3AA) begin
            errors++;
            $display("FAIL clr_push got v=%b pc=%h want v=1 pc=3aa", rd_valid, rd_pc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) ev(32'd4, 12'(12'h400 + i));
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL mid_pre_overflow got %b want 1", overflow); end
        wb_valid = 1; wb_error = 1; wb_code = 32'd2;
        reset = 1;
        cyc();
        reset = 0; wb_valid = 0; wb_error = 0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rd_valid got %b want 0", rd_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got %b want 0", overflow); end
        for (int s = 0; s < 8; s++) begin
            cnt_sel = 3'(s); #1;
            checks++; if (cnt_out !== 8'd0) begin errors++; $display("FAIL mid_cnt%0d got %0d want 0", s, cnt_out); end
        end
        cyc();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_late_valid got %b want 0", rd_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_pop();
        test_unknown();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
